// File: rtl/alu_mc.sv
// Multi-cycle ALU with a valid/ready handshake on both sides. Single-cycle ops
// resolve on the accept edge; MUL and DIVU/REMU iterate one bit per clock.
module alu_mc #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         alu_control,
  input  logic [WIDTH-1:0]   input1,
  input  logic [WIDTH-1:0]   input2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   alu_result,
  output logic               zero,
  output logic               overflow,
  output logic               illegal_op
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1011;
  localparam logic [3:0] OP_REMU = 4'b1100;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   acc;
  logic               op_rem;
  logic [SHAMT_W-1:0] count;

  logic               accept;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   comb_result;
  logic               comb_ovf;
  logic               comb_illegal;

  logic [WIDTH-1:0]   mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_fits;
  logic [WIDTH-1:0]   div_rem_next;
  logic [WIDTH-1:0]   div_quot_next;
  logic [WIDTH-1:0]   div_final;
  logic               last_step;

  // Ready also while a finished result is being drained, so single-cycle ops stream.
  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    sum          = input1 + input2;
    diff         = input1 - input2;
    shamt        = input2[SHAMT_W-1:0];
    comb_result  = '0;
    comb_ovf     = 1'b0;
    comb_illegal = 1'b0;
    case (alu_control)
      OP_AND:  comb_result = input1 & input2;
      OP_OR:   comb_result = input1 | input2;
      OP_XOR:  comb_result = input1 ^ input2;
      OP_ADD: begin
        comb_result = sum;
        comb_ovf    = (input1[WIDTH-1] == input2[WIDTH-1]) && (sum[WIDTH-1] != input1[WIDTH-1]);
      end
      OP_SUB: begin
        comb_result = diff;
        comb_ovf    = (input1[WIDTH-1] != input2[WIDTH-1]) && (diff[WIDTH-1] != input1[WIDTH-1]);
      end
      OP_SLT:  comb_result = {{(WIDTH-1){1'b0}}, ($signed(input1) < $signed(input2))};
      OP_SLTU: comb_result = {{(WIDTH-1){1'b0}}, (input1 < input2)};
      OP_SLL:  comb_result = input1 << shamt;
      OP_SRL:  comb_result = input1 >> shamt;
      OP_SRA:  comb_result = $unsigned($signed(input1) >>> shamt);
      OP_MUL, OP_DIVU, OP_REMU: comb_result = '0;
      default: comb_illegal = 1'b1;
    endcase
  end

  // op_a/op_b double as multiplicand/multiplier or dividend-quotient/divisor; acc is product or remainder.
  always_comb begin
    mul_next      = acc + (op_b[0] ? op_a : '0);
    div_shift     = {acc, op_a[WIDTH-1]};
    div_diff      = div_shift - {1'b0, op_b};
    div_fits      = !div_diff[WIDTH];
    div_rem_next  = div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_quot_next = {op_a[WIDTH-2:0], div_fits};
    div_final     = op_rem ? div_rem_next : div_quot_next;
    last_step     = (count == SHAMT_W'(WIDTH-1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      acc        <= '0;
      op_rem     <= 1'b0;
      count      <= '0;
      out_valid  <= 1'b0;
      alu_result <= '0;
      zero       <= 1'b0;
      overflow   <= 1'b0;
      illegal_op <= 1'b0;
    end else if (state == MUL) begin
      acc   <= mul_next;
      op_a  <= op_a << 1;
      op_b  <= op_b >> 1;
      count <= count + SHAMT_W'(1);
      if (last_step) begin
        alu_result <= mul_next;
        zero       <= (mul_next == '0);
        overflow   <= 1'b0;
        illegal_op <= 1'b0;
        out_valid  <= 1'b1;
        state      <= DONE;
      end
    end else if (state == DIV) begin
      acc   <= div_rem_next;
      op_a  <= div_quot_next;
      count <= count + SHAMT_W'(1);
      if (last_step) begin
        alu_result <= div_final;
        zero       <= (div_final == '0);
        overflow   <= 1'b0;
        illegal_op <= 1'b0;
        out_valid  <= 1'b1;
        state      <= DONE;
      end
    end else if (accept) begin
      count <= '0;
      acc   <= '0;
      op_a  <= input1;
      op_b  <= input2;
      case (alu_control)
        OP_MUL: begin
          out_valid <= 1'b0;
          state     <= MUL;
        end
        OP_DIVU, OP_REMU: begin
          op_rem    <= (alu_control == OP_REMU);
          out_valid <= 1'b0;
          state     <= DIV;
        end
        default: begin
          alu_result <= comb_result;
          zero       <= (comb_result == '0);
          overflow   <= comb_ovf;
          illegal_op <= comb_illegal;
          out_valid  <= 1'b1;
          state      <= DONE;
        end
      endcase
    end else if (state == DONE && out_ready) begin
      out_valid <= 1'b0;
      state     <= IDLE;
    end
  end

endmodule
